dvi_pattern_gen: RTL and testbench



---
 rtl/dvi_pkg.sv | 29 ++
 rtl/video_timing.sv | 79 +++++++
 rtl/dvi_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_dvi_pattern_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// ---------------------------------------------------------------------------
// dvi_pkg
// Shared types and constants for the DVI test-pattern generator.
//   pattern_t : selectable test patterns, in the order mode_next steps them
//   BAR_RGB   : colour of each of the eight colour bars, indexed by bar number
// ---------------------------------------------------------------------------
package dvi_pkg;

   typedef enum logic [1:0] {
      PAT_GRADIENT,
      PAT_BARS,
      PAT_CHECKER,
      PAT_SOLID
   } pattern_t;

   // Element [i] is the colour of bar i (leftmost concatenation entry is bar 7).
   // Bar i: r = ~i[1], g = ~i[2], b = ~i[0].
   localparam logic [7:0][23:0] BAR_RGB = {
      24'h000000,   // 7 black
      24'h0000FF,   // 6 blue
      24'hFF0000,   // 5 red
      24'hFF00FF,   // 4 magenta
      24'h00FF00,   // 3 green
      24'h00FFFF,   // 2 cyan
      24'hFFFF00,   // 1 yellow
      24'hFFFFFF    // 0 white
   };

endpackage

// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
// Raster counters for a resolution-parametrised video timing.
//   i_clk       : pixel clock
//   i_rst       : synchronous active-high reset, counters to (0,0)
//   o_x, o_y    : current pixel column / line
//   o_active    : pixel lies in the visible region
//   o_hsync_raw : horizontal sync at its asserted level per HSYNC_POL
//   o_vsync_raw : vertical sync at its asserted level per VSYNC_POL
//   o_eof       : last pixel of the frame (x = H_TOTAL-1, y = V_TOTAL-1)
// All outputs are combinational decodes of the counters.
// ---------------------------------------------------------------------------
module video_timing #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_active,
   output logic          o_hsync_raw,
   output logic          o_vsync_raw,
   output logic          o_eof
);

   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
   localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_x_wrap;
   logic          w_in_hs;
   logic          w_in_vs;

   assign w_x_wrap = (r_x == X_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_x_wrap) begin
         r_x <= '0;
         r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
         r_x <= r_x + 1'b1;
      end
   end

   // vsync decodes y only, so its edges fall on x==0 naturally.
   assign w_in_hs     = (r_x >= HS_START) && (r_x < HS_END);
   assign w_in_vs     = (r_y >= VS_START) && (r_y < VS_END);

   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_active    = (r_x < X_ACT) && (r_y < Y_ACT);
   assign o_hsync_raw = w_in_hs ? HSYNC_POL : ~HSYNC_POL;
   assign o_vsync_raw = w_in_vs ? VSYNC_POL : ~VSYNC_POL;
   assign o_eof       = w_x_wrap && (r_y == Y_LAST);

endmodule

// File: rtl/dvi_pattern_gen.sv
// ---------------------------------------------------------------------------
// dvi_pattern_gen
// Test-pattern source for the TMDS encoder stage: gradient, colour bars,
// checkerboard and solid fill, with frame-synchronous mode change and a
// per-frame scrolling offset.
//   clkp        : pixel clock
//   rst         : synchronous active-high reset
//   mode_next   : pulse, advance to next pattern at the next frame boundary
//   pause       : level, hold the scrolling offset
//   vga_r/g/b   : registered pixel colour (zero outside the active region)
//   hsync/vsync : registered syncs, polarity per HSYNC_POL / VSYNC_POL
//   de          : registered data enable
//   frame_start : one-cycle pulse alongside pixel (0,0)
//   mode        : pattern currently on screen
// All outputs lag the raster counters by one clock and are mutually aligned.
// ---------------------------------------------------------------------------
module dvi_pattern_gen
   import dvi_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int OFFSET_STEP = 20,
   parameter int CHECK_LOG2  = 5
) (
   input  logic       clkp,
   input  logic       rst,
   input  logic       mode_next,
   input  logic       pause,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       frame_start,
   output logic [1:0] mode
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
   localparam logic [7:0]    STEP     = 8'(OFFSET_STEP);

   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic          w_active;
   logic          w_hsync_raw;
   logic          w_vsync_raw;
   logic          w_eof;

   video_timing #(
      .H_ACTIVE  (H_ACTIVE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_ACTIVE  (V_ACTIVE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .HSYNC_POL (HSYNC_POL),
      .VSYNC_POL (VSYNC_POL)
   ) u_timing (
      .i_clk       (clkp),
      .i_rst       (rst),
      .o_x         (w_x),
      .o_y         (w_y),
      .o_active    (w_active),
      .o_hsync_raw (w_hsync_raw),
      .o_vsync_raw (w_vsync_raw),
      .o_eof       (w_eof)
   );

   // Bar index runs in lockstep with x, so no divide by BAR_W is needed.
   // It keeps counting past bar 7 in blanking, where the colour is masked.
   logic [XW-1:0] r_bar_px;
   logic [2:0]    r_bar_idx;

   always_ff @(posedge clkp) begin
      if (rst || (w_x == X_LAST)) begin
         r_bar_px  <= '0;
         r_bar_idx <= '0;
      end else if (r_bar_px == BAR_LAST) begin
         r_bar_px  <= '0;
         r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
         r_bar_px  <= r_bar_px + 1'b1;
      end
   end

   // Mode and offset only move at the frame boundary so a frame never tears.
   // A request seen mid-frame is parked in r_pending; repeats collapse.
   pattern_t   r_mode;
   logic       r_pending;
   logic [7:0] r_offset;

   always_ff @(posedge clkp) begin
      if (rst) begin
         r_mode    <= PAT_GRADIENT;
         r_pending <= 1'b0;
         r_offset  <= 8'h00;
      end else if (w_eof) begin
         if (!pause) begin
            r_offset <= r_offset + STEP;
         end
         if (r_pending || mode_next) begin
            r_mode <= pattern_t'(r_mode + 2'd1);
         end
         r_pending <= 1'b0;
      end else if (mode_next) begin
         r_pending <= 1'b1;
      end
   end

   // Pattern evaluation for the current counter position.
   logic [7:0]  w_x8;
   logic [7:0]  w_y8;
   logic [15:0] w_xo;
   logic [15:0] w_y16;
   logic        w_cell;
   logic [23:0] w_rgb;

   assign w_x8   = 8'(w_x);
   assign w_y8   = 8'(w_y);
   assign w_xo   = 16'(w_x) + 16'(r_offset);
   assign w_y16  = 16'(w_y);
   assign w_cell = |(((w_xo ^ w_y16) >> CHECK_LOG2) & 16'd1);

   always_comb begin
      w_rgb = 24'h000000;
      if (w_active) begin
         case (r_mode)
            PAT_GRADIENT: w_rgb = {w_y8 + r_offset, w_x8 + r_offset, 8'h00};
            PAT_BARS:     w_rgb = BAR_RGB[r_bar_idx];
            PAT_CHECKER:  w_rgb = w_cell ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID:    w_rgb = {3{r_offset}};
            default:      w_rgb = 24'h000000;
         endcase
      end
   end

   // Output register stage: everything leaves one clock after the counters.
   logic [23:0] r_rgb;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_de;
   logic        r_frame_start;

   always_ff @(posedge clkp) begin
      if (rst) begin
         r_rgb         <= 24'h000000;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_rgb         <= w_rgb;
         r_hsync       <= w_hsync_raw;
         r_vsync       <= w_vsync_raw;
         r_de          <= w_active;
         r_frame_start <= (w_x == '0) && (w_y == '0);
      end
   end

   assign vga_r       = r_rgb[23:16];
   assign vga_g       = r_rgb[15:8];
   assign vga_b       = r_rgb[7:0];
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign frame_start = r_frame_start;
   assign mode        = r_mode;

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_dvi_pattern_gen
// Directed bench for dvi_pattern_gen on a reduced raster (80x14 total,
// 64x8 active) so that many frames fit in a short run.
// ---------------------------------------------------------------------------
module tb_dvi_pattern_gen;

   localparam int HA    = 64;
   localparam int HF    = 4;
   localparam int HS    = 8;
   localparam int HB    = 4;
   localparam int VA    = 8;
   localparam int VF    = 2;
   localparam int VS    = 2;
   localparam int VB    = 2;
   localparam int HT    = HA + HF + HS + HB;   // 80
   localparam int VT    = VA + VF + VS + VB;   // 14
   localparam int FRAME = HT * VT;             // 1120

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_next;
   logic       pause;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic       frame_start;
   logic [1:0] mode;
   logic [23:0] rgb;

   assign rgb = {vga_r, vga_g, vga_b};

   always #5 clk = ~clk;

   dvi_pattern_gen #(
      .H_ACTIVE    (HA),
      .H_FP        (HF),
      .H_SYNC      (HS),
      .H_BP        (HB),
      .V_ACTIVE    (VA),
      .V_FP        (VF),
      .V_SYNC      (VS),
      .V_BP        (VB),
      .HSYNC_POL   (1'b0),
      .VSYNC_POL   (1'b0),
      .OFFSET_STEP (20),
      .CHECK_LOG2  (2)
   ) dut (
      .clkp        (clk),
      .rst         (rst),
      .mode_next   (mode_next),
      .pause       (pause),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start),
      .mode        (mode)
   );

   int n_vec = 0;
   int n_err = 0;
   int pos   = 0;   // output pixel index within the current frame

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pos++;
   endtask

   task automatic goto_px(input int x, input int y);
      int tgt;
      tgt = y * HT + x;
      while (pos < tgt) step();
   endtask

   task automatic pulse_next();
      mode_next = 1'b1;
      step();
      mode_next = 1'b0;
   endtask

   // Advance to the next frame_start; the distance must be the rest of a frame.
   task automatic wait_fs(input string tag);
      int  n;
      int  want;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      want = FRAME - pos;
      while (!seen && n < 2 * FRAME + 4) begin
         @(posedge clk);
         #1;
         n++;
         if (frame_start) seen = 1'b1;
      end
      chk(tag, 32'(n), 32'(want));
      pos = 0;
   endtask

   // Full-frame comparison of frame 0 against a position-based model.
   task automatic sweep_frame0();
      int          kx;
      int          ky;
      logic        e_act;
      logic        e_hs;
      logic        e_vs;
      logic        e_fs;
      logic [23:0] e_rgb;
      int          c_de;
      int          c_hs;
      int          c_vs;
      c_de = 0;
      c_hs = 0;
      c_vs = 0;
      for (int k = 0; k < FRAME; k++) begin
         kx    = k % HT;
         ky    = k / HT;
         e_act = (kx < HA) && (ky < VA);
         e_hs  = !((kx >= HA + HF) && (kx < HA + HF + HS));
         e_vs  = !((ky >= VA + VF) && (ky < VA + VF + VS));
         e_fs  = (k == 0);
         e_rgb = e_act ? {8'(ky), 8'(kx), 8'h00} : 24'h000000;
         chk("f0_sweep", {4'h0, frame_start, de, hsync, vsync, rgb},
             {4'h0, e_fs, e_act, e_hs, e_vs, e_rgb});
         if (de) c_de++;
         if (!hsync) c_hs++;
         if (!vsync) c_vs++;
         step();
      end
      chk("f0_de_count", 32'(c_de), 32'(HA * VA));
      chk("f0_hs_count", 32'(c_hs), 32'(HS * VT));
      chk("f0_vs_count", 32'(c_vs), 32'(VS * HT));
      chk("f1_fs_period", 32'(frame_start), 32'd1);
      pos = 0;
   endtask

   initial begin
      rst       = 1'b1;
      mode_next = 1'b0;
      pause     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {fs_de_hs_vs(), 2'(mode), rgb}, {4'b0011, 2'd0, 24'h000000});
      rst = 1'b0;
      @(posedge clk);
      #1;
      pos = 0;
      chk("first_fs", {frame_start, de}, 2'b11);

      // Frame 0: mode 0, offset 0
      sweep_frame0();

      // Frame 1: offset 20; hold pause across its end
      goto_px(10, 3);
      chk("grad_f1", rgb, 24'h171E00);
      pause = 1'b1;
      wait_fs("f2_period");
      pause = 1'b0;

      // Frame 2: offset unchanged, three requests collapse to one advance
      goto_px(10, 3);
      chk("grad_paused", rgb, 24'h171E00);
      goto_px(5, 4);
      pulse_next();
      goto_px(30, 5);
      pulse_next();
      goto_px(70, 12);
      pulse_next();
      goto_px(10, 13);
      chk("mode_hold", 32'(mode), 32'd0);
      wait_fs("f3_period");
      chk("mode_adv", 32'(mode), 32'd1);

      // Frame 3: colour bars (BAR_W = 8)
      goto_px(0, 2);
      chk("bar0", rgb, 24'hFFFFFF);
      goto_px(8, 2);
      chk("bar1", rgb, 24'hFFFF00);
      goto_px(16, 2);
      chk("bar2", rgb, 24'h00FFFF);
      goto_px(48, 2);
      chk("bar6", rgb, 24'h0000FF);
      goto_px(63, 2);
      chk("bar7", rgb, 24'h000000);
      goto_px(64, 2);
      chk("bar_hblank", {de, rgb}, {1'b0, 24'h000000});

      // Request on the end-of-frame cycle itself
      while (pos < FRAME - 2) step();
      pulse_next();
      chk("eof_mode", 32'(mode), 32'd2);
      step();
      chk("eof_fs", 32'(frame_start), 32'd1);
      pos = 0;

      // Frame 4: checker, offset 60, cell 4 px
      chk("chk_0_0", rgb, 24'hFFFFFF);
      goto_px(4, 0);
      chk("chk_4_0", rgb, 24'h000000);
      goto_px(4, 4);
      chk("chk_4_4", rgb, 24'hFFFFFF);
      goto_px(2, 5);
      chk("chk_2_5", rgb, 24'h000000);
      wait_fs("f5_period");
      chk("eof_no_pending", 32'(mode), 32'd2);

      // Frame 5 -> mode 3; frame 6 solid at offset 100, then wrap to mode 0
      goto_px(3, 3);
      pulse_next();
      wait_fs("f6_period");
      chk("mode3", 32'(mode), 32'd3);
      goto_px(5, 5);
      chk("solid_f6", rgb, 24'h646464);
      pulse_next();
      wait_fs("f7_period");
      chk("mode_wrap", 32'(mode), 32'd0);

      // Frames 7..9: step back to mode 3
      for (int i = 0; i < 3; i++) begin
         goto_px(1, 1);
         pulse_next();
         wait_fs("fx_period");
      end
      chk("mode3_again", 32'(mode), 32'd3);
      for (int i = 0; i < 3; i++) wait_fs("fy_period");

      // Frame 13: offset 240; frame 14: offset 260 mod 256 = 4
      goto_px(5, 5);
      chk("solid_f13", rgb, 24'hF0F0F0);
      wait_fs("f14_period");
      goto_px(5, 5);
      chk("offset_wrap", rgb, 24'h040404);
      goto_px(70, 5);
      chk("solid_hblank", rgb, 24'h000000);
      goto_px(5, 10);
      chk("solid_vblank", {de, rgb}, {1'b0, 24'h000000});

      // Step to mode 2 (checker) for the mid-line reset
      for (int i = 0; i < 3; i++) begin
         goto_px(6, 11);
         pulse_next();
         wait_fs("fz_period");
      end
      chk("mode2_f17", 32'(mode), 32'd2);
      goto_px(20, 3);
      chk("chk_pre_rst", {de, rgb}, {1'b1, 24'hFFFFFF});
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid", {fs_de_hs_vs(), 2'(mode), rgb}, {4'b0011, 2'd0, 24'h000000});
      rst = 1'b0;
      @(posedge clk);
      #1;
      pos = 0;
      chk("restart_fs", {frame_start, de, rgb}, {2'b11, 24'h000000});
      goto_px(10, 3);
      chk("grad_restart", rgb, 24'h030A00);
      wait_fs("restart_period");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   function automatic logic [3:0] fs_de_hs_vs();
      return {frame_start, de, hsync, vsync};
   endfunction

endmodule
